// File: rtl/fifo.sv
// Single-clock FIFO with first-word-fall-through read port.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module fifo #(
    parameter int unsigned DATAW = 8,
    parameter int unsigned ADDRW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [DATAW-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [DATAW-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned Depth = 2 ** ADDRW;

    logic [DATAW-1:0] mem_q [Depth];
    logic [ADDRW:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDRW:0]   rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    always_comb begin
        o_empty = (wr_ptr_q == rd_ptr_q);
        o_full  = (wr_ptr_q[ADDRW-1:0] == rd_ptr_q[ADDRW-1:0]) &&
                  (wr_ptr_q[ADDRW] != rd_ptr_q[ADDRW]);
    end

    // Each request is qualified by the flags as they stood before the edge.
    always_comb begin
        push     = i_wr_en && !o_full;
        pop      = i_rd_en && !o_empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q[ADDRW-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = mem_q[rd_ptr_q[ADDRW-1:0]];

endmodule

// File: tb/tb_fifo.sv
// Directed self-checking bench for fifo (DATAW=8, ADDRW=3, depth 8).
module tb_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_wr_en;
    logic [7:0] i_wr_data;
    logic       i_rd_en;
    logic [7:0] o_rd_data;
    logic       o_full;
    logic       o_empty;

    int checks = 0;
    int failures = 0;

    fifo #(
        .DATAW(8),
        .ADDRW(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_wr_en  (i_wr_en),
        .i_wr_data(i_wr_data),
        .i_rd_en  (i_rd_en),
        .o_rd_data(o_rd_data),
        .o_full   (o_full),
        .o_empty  (o_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus; outputs are sampled 1ns after the edge.
    task automatic cycle(input logic we, input logic [7:0] wd, input logic re);
        i_wr_en   = we;
        i_wr_data = wd;
        i_rd_en   = re;
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle(1'b1, 8'hAA, 1'b1);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        i_wr_en   = 1'b0;
        i_wr_data = '0;
        i_rd_en   = 1'b0;

        // Reset overrides simultaneous push/pop.
        do_reset();
        check("rst_empty", o_empty, 1);
        check("rst_full", o_full, 0);

        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 8'h0, 1'b1);
            check("idle_pop_empty", o_empty, 1);
        end

        // Fill with 15..22.
        for (int i = 0; i < 8; i++) begin
            check("fill_full_before", o_full, 0);
            cycle(1'b1, 8'(15 + i), 1'b0);
            check("fill_empty", o_empty, 0);
            check("fill_head", o_rd_data, 15);
        end
        check("fill_full", o_full, 1);

        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, 8'd99, 1'b0);
            check("ovf_full", o_full, 1);
            check("ovf_head", o_rd_data, 15);
        end

        // Drain 15..22; 99 must never appear.
        for (int k = 1; k <= 8; k++) begin
            cycle(1'b0, 8'h0, 1'b1);
            check("drain_full", o_full, 0);
            if (k < 8) begin
                check("drain_head", o_rd_data, 32'(15 + k));
                check("drain_nempty", o_empty, 0);
            end
        end
        check("drain_empty", o_empty, 1);
        cycle(1'b0, 8'h0, 1'b1);
        check("extra_pop_empty", o_empty, 1);
        check("extra_pop_full", o_full, 0);

        // A pointer that moved on the ignored pop would misplace this word.
        cycle(1'b1, 8'd33, 1'b0);
        check("after_extra_head", o_rd_data, 33);
        cycle(1'b0, 8'h0, 1'b1);
        check("after_extra_empty", o_empty, 1);

        // Simultaneous push/pop at occupancy 4.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 8'(i), 1'b0);
        check("sim4_head0", o_rd_data, 1);
        cycle(1'b1, 8'd5, 1'b1);
        check("sim4_head", o_rd_data, 2);
        check("sim4_full", o_full, 0);
        for (int k = 2; k <= 5; k++) begin
            check("sim4_seq", o_rd_data, 32'(k));
            check("sim4_nempty", o_empty, 0);
            cycle(1'b0, 8'h0, 1'b1);
        end
        check("sim4_empty", o_empty, 1);

        // Simultaneous push/pop while full: push is dropped.
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(10 + i), 1'b0);
        check("simf_full0", o_full, 1);
        cycle(1'b1, 8'd7, 1'b1);
        check("simf_full", o_full, 0);
        check("simf_head", o_rd_data, 11);
        for (int k = 11; k <= 17; k++) begin
            check("simf_seq", o_rd_data, 32'(k));
            cycle(1'b0, 8'h0, 1'b1);
        end
        check("simf_empty", o_empty, 1);

        // Steady push/pop at occupancy 3 across several pointer wraps.
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(100 + i), 1'b0);
        for (int n = 0; n < 20; n++) begin
            check("wrap_head", o_rd_data, 32'(100 + n));
            cycle(1'b1, 8'(103 + n), 1'b1);
            check("wrap_full", o_full, 0);
            check("wrap_empty", o_empty, 0);
        end
        for (int n = 20; n < 23; n++) begin
            check("wrap_tail", o_rd_data, 32'(100 + n));
            cycle(1'b0, 8'h0, 1'b1);
        end
        check("wrap_empty_end", o_empty, 1);

        // Reset while holding 5 words.
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(60 + i), 1'b0);
        check("mid_nempty", o_empty, 0);
        do_reset();
        check("mid_rst_empty", o_empty, 1);
        check("mid_rst_full", o_full, 0);
        cycle(1'b1, 8'd42, 1'b0);
        check("mid_push_head", o_rd_data, 42);
        check("mid_push_nempty", o_empty, 0);
        cycle(1'b0, 8'h0, 1'b1);
        check("mid_pop_empty", o_empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
